reg_bank: RTL and testbench

Parametrised multi-port register bank: DEPTH registers of WIDTH bits, one write port, two independently registered read ports with write-through bypass, per-entry valid tracking and a sequenced clear-all operation. It is the general-purpose operand store for the matrix datapath: the op/result path writes it, and two operand paths read it concurrently.

---
 rtl/reg_bank_pkg.sv | 14 +
 rtl/reg_bank_if.sv | 32 +++
 rtl/reg_bank_rd_port.sv | 63 ++++++
 rtl/reg_bank.sv | 125 ++++++++++++
 tb/tb_reg_bank.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the operand register bank.
// The address width leaves room for the 1-based entries plus the null address 0.
package reg_bank_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int addr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Bus bundle between the datapath (master) and the register bank (slave).
interface reg_bank_if #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
);
    import reg_bank_pkg::*;

    localparam int AW = addr_width(DEPTH);

    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr_a;
    logic [AW-1:0]    rd_addr_b;
    logic             clr_req;
    logic             busy;
    logic [WIDTH-1:0] rd_val_a;
    logic             rd_valid_a;
    logic [WIDTH-1:0] rd_val_b;
    logic             rd_valid_b;
    logic [DEPTH-1:0] valid_mask;

    modport master (
        output wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
        input  busy, rd_val_a, rd_valid_a, rd_val_b, rd_valid_b, valid_mask
    );

    modport slave (
        input  wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
        output busy, rd_val_a, rd_valid_a, rd_val_b, rd_valid_b, valid_mask
    );

endinterface

// File: rtl/reg_bank_rd_port.sv
// One registered read port: selects an entry, applies clear/write bypass,
// and holds its output when given the null or an out-of-range address.
module reg_bank_rd_port #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] entry_data [DEPTH+1],
    input  logic [DEPTH:0]   entry_valid,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_index,
    output logic [WIDTH-1:0] rd_val,
    output logic             rd_valid
);

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    logic             addr_legal;
    logic [AW-1:0]    sel;
    logic [WIDTH-1:0] rd_val_reg, rd_val_next;
    logic             rd_valid_reg, rd_valid_next;

    assign addr_legal = (rd_addr != '0) && (rd_addr <= DEPTH_A);
    // Index 0 is a constant-zero slot, so steering illegal addresses there keeps the mux in range.
    assign sel        = addr_legal ? rd_addr : '0;

    always_comb begin
        rd_val_next   = rd_val_reg;
        rd_valid_next = rd_valid_reg;
        if (addr_legal) begin
            if (clr_en && (clr_index == rd_addr)) begin
                rd_val_next   = '0;
                rd_valid_next = 1'b0;
            end else if (wr_en && (wr_addr == rd_addr)) begin
                rd_val_next   = wr_data;
                rd_valid_next = 1'b1;
            end else begin
                rd_val_next   = entry_data[sel];
                rd_valid_next = entry_valid[sel];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_val_reg   <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_val_reg   <= rd_val_next;
            rd_valid_reg <= rd_valid_next;
        end
    end

    assign rd_val   = rd_val_reg;
    assign rd_valid = rd_valid_reg;

endmodule

// File: rtl/reg_bank.sv
// Operand register bank: DEPTH entries, one write port, two bypassed read
// ports, per-entry valid bits and a one-entry-per-cycle clear sequence.
module reg_bank #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    reg_bank_if.slave bus
);
    import reg_bank_pkg::*;

    localparam int            AW      = addr_width(DEPTH);
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    state_t           state_reg, state_next;
    logic [AW-1:0]    index_reg, index_next;
    logic             wr_en;
    logic             clr_en;
    logic [WIDTH-1:0] entry_data [DEPTH+1];
    logic [DEPTH:0]   entry_valid;

    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        wr_en      = 1'b0;
        clr_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                // A clear request wins over a write presented in the same cycle.
                if (bus.clr_req) begin
                    state_next = CLEAR;
                    index_next = ONE_A;
                end else begin
                    wr_en = (bus.wr_addr != '0) && (bus.wr_addr <= DEPTH_A);
                end
            end
            CLEAR: begin
                clr_en = 1'b1;
                if (index_reg == DEPTH_A) begin
                    state_next = IDLE;
                    index_next = ONE_A;
                end else begin
                    index_next = index_reg + ONE_A;
                end
            end
            default: begin
                state_next = IDLE;
                index_next = ONE_A;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            index_reg <= ONE_A;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
        end
    end

    assign entry_data[0] = '0;
    assign entry_valid[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi <= DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] data_reg;
            logic             valid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (clr_en && (index_reg == AW'(gi))) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (wr_en && (bus.wr_addr == AW'(gi))) begin
                    data_reg  <= bus.wr_data;
                    valid_reg <= 1'b1;
                end
            end

            assign entry_data[gi]  = data_reg;
            assign entry_valid[gi] = valid_reg;
        end
    endgenerate

    reg_bank_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_a (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (bus.rd_addr_a),
        .entry_data  (entry_data),
        .entry_valid (entry_valid),
        .wr_en       (wr_en),
        .wr_addr     (bus.wr_addr),
        .wr_data     (bus.wr_data),
        .clr_en      (clr_en),
        .clr_index   (index_reg),
        .rd_val      (bus.rd_val_a),
        .rd_valid    (bus.rd_valid_a)
    );

    reg_bank_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_rd_b (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (bus.rd_addr_b),
        .entry_data  (entry_data),
        .entry_valid (entry_valid),
        .wr_en       (wr_en),
        .wr_addr     (bus.wr_addr),
        .wr_data     (bus.wr_data),
        .clr_en      (clr_en),
        .clr_index   (index_reg),
        .rd_val      (bus.rd_val_b),
        .rd_valid    (bus.rd_valid_b)
    );

    assign bus.busy       = (state_reg == CLEAR);
    assign bus.valid_mask = entry_valid[DEPTH:1];

endmodule

// File: tb/tb_reg_bank.sv
// Directed and random stimulus for reg_bank, checked against an array-based
// model of the bank's behaviour, with explicit checks on the key scenarios.
module tb_reg_bank;

    localparam int WIDTH = 9;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Model: entry contents, valid flags, clear progress, expected port outputs.
    int m_data  [1:DEPTH];
    bit m_valid [1:DEPTH];
    bit m_busy;
    int m_pos;
    int e_val_a, e_val_b;
    bit e_vld_a, e_vld_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 1; k <= DEPTH; k++) begin
            m_data[k]  = 0;
            m_valid[k] = 1'b0;
        end
        m_busy  = 1'b0;
        m_pos   = 1;
        e_val_a = 0; e_vld_a = 1'b0;
        e_val_b = 0; e_vld_b = 1'b0;
    endtask

    task automatic resolve(input int addr, input int cpos, input bit wr_ok, input int wa,
                           input int wd, inout int val, inout bit vld);
        if (addr < 1 || addr > DEPTH) return;
        if (addr == cpos) begin
            val = 0; vld = 1'b0;
        end else if (wr_ok && addr == wa) begin
            val = wd; vld = 1'b1;
        end else begin
            val = m_data[addr]; vld = m_valid[addr];
        end
    endtask

    task automatic model_edge();
        int  wa, wd, cpos;
        bit  wr_ok;
        wa    = int'(bus.wr_addr);
        wd    = int'(bus.wr_data);
        cpos  = m_busy ? m_pos : 0;
        wr_ok = !m_busy && !bus.clr_req && wa >= 1 && wa <= DEPTH;
        resolve(int'(bus.rd_addr_a), cpos, wr_ok, wa, wd, e_val_a, e_vld_a);
        resolve(int'(bus.rd_addr_b), cpos, wr_ok, wa, wd, e_val_b, e_vld_b);
        if (m_busy) begin
            m_data[m_pos]  = 0;
            m_valid[m_pos] = 1'b0;
            m_pos++;
            if (m_pos > DEPTH) begin
                m_busy = 1'b0;
                m_pos  = 1;
            end
        end else if (bus.clr_req) begin
            m_busy = 1'b1;
            m_pos  = 1;
        end else if (wr_ok) begin
            m_data[wa]  = wd;
            m_valid[wa] = 1'b1;
        end
    endtask

    task automatic check_all();
        logic [DEPTH-1:0] mask;
        for (int k = 1; k <= DEPTH; k++) mask[k-1] = m_valid[k];
        check("rd_val_a",   32'(bus.rd_val_a),   32'(e_val_a));
        check("rd_valid_a", 32'(bus.rd_valid_a), 32'(e_vld_a));
        check("rd_val_b",   32'(bus.rd_val_b),   32'(e_val_b));
        check("rd_valid_b", 32'(bus.rd_valid_b), 32'(e_vld_b));
        check("busy",       32'(bus.busy),       32'(m_busy));
        check("valid_mask", 32'(bus.valid_mask), 32'(mask));
    endtask

    task automatic cycle(input int wa, input int wd, input int ra, input int rb, input bit clr);
        bus.wr_addr   = AW'(wa);
        bus.wr_data   = WIDTH'(wd);
        bus.rd_addr_a = AW'(ra);
        bus.rd_addr_b = AW'(rb);
        bus.clr_req   = clr;
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        $display("cyc %0d wa=%0d wd=%03h ra=%0d rb=%0d clr=%0b -> a=%03h/%0b b=%03h/%0b busy=%0b mask=%b",
                 cyc, wa, wd, ra, rb, clr, bus.rd_val_a, bus.rd_valid_a,
                 bus.rd_val_b, bus.rd_valid_b, bus.busy, bus.valid_mask);
        check_all();
    endtask

    // Asynchronous reset raised between clock edges; outputs must clear at once.
    task automatic async_reset();
        rst = 1'b1;
        #1;
        model_reset();
        $display("cyc %0d async reset asserted", cyc);
        check_all();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_mask", 32'(bus.valid_mask), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        bus.clr_req   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("reset_val_a", 32'(bus.rd_val_a), 32'd0);
        check("reset_busy",  32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Empty bank reads back zero with valid 0.
        for (int k = 1; k <= DEPTH; k++) begin
            cycle(0, 0, k, k, 1'b0);
            check("empty_rd", 32'({bus.rd_valid_a, bus.rd_val_a}), 32'd0);
        end

        // Write then read; port B given the null address holds.
        cycle(3, 'h1A5, 0, 0, 1'b0);
        cycle(0, 0, 3, 0, 1'b0);
        check("wr_rd_a",   32'(bus.rd_val_a), 32'h1A5);
        check("wr_rd_vld", 32'(bus.rd_valid_a), 32'd1);
        check("mask_0100", 32'(bus.valid_mask), 32'b0100);
        check("hold_b",    32'(bus.rd_val_b), 32'd0);

        // Write-through on both ports.
        cycle(2, 'h0FF, 2, 2, 1'b0);
        check("bypass_a", 32'({bus.rd_valid_a, bus.rd_val_a}), 32'h2FF);
        check("bypass_b", 32'({bus.rd_valid_b, bus.rd_val_b}), 32'h2FF);

        // Fill, then clear with a colliding write that must be dropped.
        cycle(1, 'h011, 0, 0, 1'b0);
        cycle(4, 'h144, 0, 0, 1'b0);
        cycle(1, 'h055, 1, 0, 1'b1);
        check("drop_wr", 32'(bus.rd_val_a), 32'h011);
        check("busy_up", 32'(bus.busy), 32'd1);
        cycle(4, 'h1EE, 1, 4, 1'b0);
        check("clr1_rd",   32'({bus.rd_valid_a, bus.rd_val_a}), 32'd0);
        check("mask_1110", 32'(bus.valid_mask), 32'b1110);
        cycle(0, 0, 2, 2, 1'b1);
        check("clr2_rd",   32'({bus.rd_valid_b, bus.rd_val_b}), 32'd0);
        check("mask_1100", 32'(bus.valid_mask), 32'b1100);
        cycle(0, 0, 0, 0, 1'b0);
        check("mask_1000", 32'(bus.valid_mask), 32'b1000);
        check("busy_held", 32'(bus.busy), 32'd1);
        cycle(0, 0, 0, 0, 1'b0);
        check("mask_0000", 32'(bus.valid_mask), 32'b0000);
        check("busy_down", 32'(bus.busy), 32'd0);
        cycle(4, 'h077, 4, 0, 1'b0);
        check("first_idle_wr", 32'(bus.rd_val_a), 32'h077);

        // Reset in the middle of a clear sequence.
        cycle(1, 'h101, 0, 0, 1'b0);
        cycle(2, 'h102, 0, 0, 1'b0);
        cycle(0, 0, 0, 0, 1'b1);
        cycle(0, 0, 3, 4, 1'b0);
        async_reset();
        cycle(1, 'h12A, 0, 0, 1'b0);
        cycle(0, 0, 0, 1, 1'b0);
        check("post_rst_wr", 32'({bus.rd_valid_b, bus.rd_val_b}), 32'h32A);

        // Random traffic including out-of-range addresses, clears and resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                async_reset();
            end else begin
                cycle(int'($urandom_range(0, 7)), int'($urandom_range(0, 511)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      $urandom_range(0, 15) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
